// File: rtl/multi_counter.sv
// Bank of independent event counters with wrap/saturate overflow, sticky overflow flags,
// threshold flags and a registered read port that can clear the channel it reads.
module multi_counter #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_INPUT_SIZE = 2,
  parameter int unsigned CNT_SIZE       = 16,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                               clk,
  input  logic                               reset_L,
  input  logic                               clear,
  input  logic                               sat_mode,
  input  logic [NUM_CH-1:0]                  en,
  input  logic [NUM_CH*CNT_INPUT_SIZE-1:0]   inc,
  input  logic [CNT_SIZE-1:0]                threshold,
  input  logic                               rd_req,
  input  logic [CH_W-1:0]                    rd_ch,
  input  logic                               rd_clr,
  output logic                               rd_valid,
  output logic [CNT_SIZE-1:0]                rd_data,
  output logic                               rd_ovf,
  output logic                               rd_err,
  output logic [NUM_CH*CNT_SIZE-1:0]         value,
  output logic [NUM_CH-1:0]                  non_zero_value,
  output logic [NUM_CH-1:0]                  error_overflow,
  output logic [NUM_CH-1:0]                  threshold_hit
);

  localparam logic [CH_W:0] NumChW = (CH_W+1)'(NUM_CH);

  logic [CNT_SIZE-1:0]       cnt_q [NUM_CH];
  logic [CNT_SIZE-1:0]       cnt_d [NUM_CH];
  logic [CNT_INPUT_SIZE-1:0] inc_ch [NUM_CH];
  logic [CNT_SIZE:0]         sum_ch [NUM_CH];
  logic [NUM_CH-1:0]         ovf_q, ovf_d;

  logic                rd_ok, rd_clr_en;
  logic                rd_valid_q, rd_ovf_q, rd_err_q;
  logic [CNT_SIZE-1:0] rd_data_q;
  logic [CNT_SIZE-1:0] rd_data_d;
  logic                rd_ovf_d;

  assign rd_ok     = ({1'b0, rd_ch} < NumChW);
  assign rd_clr_en = rd_req & rd_clr & rd_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign inc_ch[i] = inc[i*CNT_INPUT_SIZE +: CNT_INPUT_SIZE];
    // One extra bit so the carry-out marks an overflow.
    assign sum_ch[i] = {1'b0, cnt_q[i]} + (CNT_SIZE+1)'(inc_ch[i]);

    assign value[i*CNT_SIZE +: CNT_SIZE] = cnt_q[i];
    assign non_zero_value[i]             = |cnt_q[i];
    assign threshold_hit[i]              = (threshold != '0) && (cnt_q[i] >= threshold);
  end

  assign error_overflow = ovf_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (rd_clr_en && (rd_ch == CH_W'(i))) begin
        // Same-cycle increment restarts the count rather than being dropped.
        cnt_d[i] = en[i] ? CNT_SIZE'(inc_ch[i]) : '0;
        ovf_d[i] = 1'b0;
      end else if (en[i]) begin
        if (sum_ch[i][CNT_SIZE]) begin
          cnt_d[i] = sat_mode ? '1 : sum_ch[i][CNT_SIZE-1:0];
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = sum_ch[i][CNT_SIZE-1:0];
        end
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ok && (rd_ch == CH_W'(i))) begin
        rd_data_d = cnt_q[i];
        rd_ovf_d  = ovf_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_req;
      if (rd_req) begin
        rd_data_q <= rd_data_d;
        rd_ovf_q  <= rd_ovf_d;
        rd_err_q  <= ~rd_ok;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_ovf   = rd_ovf_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_multi_counter.sv
// Randomised and directed checks of multi_counter against an arithmetic reference model.
module tb_multi_counter;

  localparam int NCH  = 5;
  localparam int CIS  = 2;
  localparam int CS   = 16;
  localparam int CHW  = 3;
  localparam int MAXV = 65535;

  logic                 clk = 1'b0;
  logic                 reset_L, clear, sat_mode;
  logic [NCH-1:0]       en;
  logic [NCH*CIS-1:0]   inc;
  logic [CS-1:0]        threshold;
  logic                 rd_req, rd_clr;
  logic [CHW-1:0]       rd_ch;
  logic                 rd_valid, rd_ovf, rd_err;
  logic [CS-1:0]        rd_data;
  logic [NCH*CS-1:0]    value;
  logic [NCH-1:0]       non_zero_value, error_overflow, threshold_hit;

  multi_counter #(.NUM_CH(NCH), .CNT_INPUT_SIZE(CIS), .CNT_SIZE(CS)) u_dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .clear          (clear),
    .sat_mode       (sat_mode),
    .en             (en),
    .inc            (inc),
    .threshold      (threshold),
    .rd_req         (rd_req),
    .rd_ch          (rd_ch),
    .rd_clr         (rd_clr),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_ovf         (rd_ovf),
    .rd_err         (rd_err),
    .value          (value),
    .non_zero_value (non_zero_value),
    .error_overflow (error_overflow),
    .threshold_hit  (threshold_hit)
  );

  always #5 clk = ~clk;

  int unsigned mval [NCH];
  bit          movf [NCH];
  bit          e_rd_valid, e_rd_ovf, e_rd_err;
  int unsigned e_rd_data;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mval[c] = 0;
      movf[c] = 1'b0;
    end
    e_rd_valid = 1'b0;
    e_rd_data  = 0;
    e_rd_ovf   = 1'b0;
    e_rd_err   = 1'b0;
  endtask

  // Applies one clock edge worth of the counter rules to the model.
  task automatic model_edge();
    int unsigned iv, s;
    e_rd_valid = rd_req;
    if (rd_req) begin
      if (int'(rd_ch) < NCH) begin
        e_rd_data = mval[rd_ch];
        e_rd_ovf  = movf[rd_ch];
        e_rd_err  = 1'b0;
      end else begin
        e_rd_data = 0;
        e_rd_ovf  = 1'b0;
        e_rd_err  = 1'b1;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      iv = int'(inc >> (c*CIS)) & ((1 << CIS) - 1);
      if (clear) begin
        mval[c] = 0;
        movf[c] = 1'b0;
      end else if (rd_req && rd_clr && int'(rd_ch) == c) begin
        mval[c] = en[c] ? iv : 0;
        movf[c] = 1'b0;
      end else if (en[c]) begin
        s = mval[c] + iv;
        if (s > MAXV) begin
          movf[c] = 1'b1;
          mval[c] = sat_mode ? MAXV : s - (MAXV + 1);
        end else begin
          mval[c] = s;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH*CS-1:0] ev;
    logic [NCH-1:0]    enz, eovf, ethr;
    for (int c = 0; c < NCH; c++) begin
      ev[c*CS +: CS] = CS'(mval[c]);
      enz[c]  = mval[c] != 0;
      eovf[c] = movf[c];
      ethr[c] = (threshold != 0) && (mval[c] >= int'(threshold));
    end
    check_eq({tag, ".value"}, value, ev);
    check_eq({tag, ".nz"}, non_zero_value, enz);
    check_eq({tag, ".ovf"}, error_overflow, eovf);
    check_eq({tag, ".thr"}, threshold_hit, ethr);
    check_eq({tag, ".rd_valid"}, rd_valid, e_rd_valid);
    check_eq({tag, ".rd_data"}, rd_data, e_rd_data);
    check_eq({tag, ".rd_ovf"}, rd_ovf, e_rd_ovf);
    check_eq({tag, ".rd_err"}, rd_err, e_rd_err);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_inc(input int ch, input int v);
    inc[ch*CIS +: CIS] = CIS'(v);
  endtask

  task automatic idle_inputs();
    clear = 1'b0; en = '0; inc = '0; rd_req = 1'b0; rd_clr = 1'b0; rd_ch = '0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    tick("clear");
    clear = 1'b0;
  endtask

  // Brings ch0 to 0xFFFE by repeated +3 then a final +2.
  task automatic preset_ch0();
    idle_inputs();
    en[0] = 1'b1;
    set_inc(0, 3);
    repeat (21844) tick("preset");
    set_inc(0, 2);
    tick("preset");
    check_eq("preset_fffe", value[0 +: CS], 16'hFFFE);
  endtask

  initial begin
    reset_L = 1'b0; sat_mode = 1'b0; threshold = '0;
    idle_inputs();
    model_reset();
    #3;
    check_all("reset");
    #4 reset_L = 1'b1;

    // Basic counting on four channels.
    en = 5'b01111;
    set_inc(0, 1); set_inc(1, 2); set_inc(2, 3); set_inc(3, 0);
    repeat (10) tick("basic");
    check_eq("basic_v0", value[0*CS +: CS], 16'd10);
    check_eq("basic_v1", value[1*CS +: CS], 16'd20);
    check_eq("basic_v2", value[2*CS +: CS], 16'd30);
    check_eq("basic_v3", value[3*CS +: CS], 16'd0);
    check_eq("basic_nz", non_zero_value[3:0], 4'b0111);
    check_eq("basic_ovf", error_overflow, 5'b0);

    // Wrap mode overflow.
    do_clear();
    sat_mode = 1'b0;
    preset_ch0();
    set_inc(0, 3);
    tick("wrap");
    check_eq("wrap_v", value[0 +: CS], 16'h0001);
    check_eq("wrap_ovf", error_overflow[0], 1'b1);
    set_inc(0, 1);
    tick("wrap2");
    check_eq("wrap2_v", value[0 +: CS], 16'h0002);
    check_eq("wrap2_ovf", error_overflow[0], 1'b1);

    // Saturate mode overflow.
    do_clear();
    sat_mode = 1'b1;
    preset_ch0();
    set_inc(0, 3);
    tick("sat");
    check_eq("sat_v", value[0 +: CS], 16'hFFFF);
    check_eq("sat_ovf", error_overflow[0], 1'b1);
    set_inc(0, 2);
    tick("sat2");
    check_eq("sat2_v", value[0 +: CS], 16'hFFFF);
    sat_mode = 1'b0;

    // Read-clear with a same-cycle increment.
    do_clear();
    en[2] = 1'b1;
    set_inc(2, 3);
    repeat (21) tick("rc_pre");
    set_inc(2, 1);
    tick("rc_pre");
    rd_req = 1'b1; rd_ch = 3'd2; rd_clr = 1'b1;
    tick("rdclr");
    check_eq("rdclr_valid", rd_valid, 1'b1);
    check_eq("rdclr_data", rd_data, 16'h0040);
    check_eq("rdclr_ovf", rd_ovf, 1'b0);
    check_eq("rdclr_v2", value[2*CS +: CS], 16'h0001);
    idle_inputs();
    tick("rd_hold");
    check_eq("rd_hold_valid", rd_valid, 1'b0);
    check_eq("rd_hold_data", rd_data, 16'h0040);

    // Clear outranks read-clear but the read still returns the old count.
    do_clear();
    en[1] = 1'b1;
    set_inc(1, 1);
    repeat (5) tick("pri_pre");
    clear = 1'b1; rd_req = 1'b1; rd_ch = 3'd1;
    tick("prio");
    check_eq("prio_data", rd_data, 16'h0005);
    check_eq("prio_values", value, '0);
    check_eq("prio_ovf", error_overflow, 5'b0);
    idle_inputs();
    rd_req = 1'b1; rd_ch = 3'd5; rd_clr = 1'b1;
    tick("rderr");
    check_eq("rderr_err", rd_err, 1'b1);
    check_eq("rderr_data", rd_data, 16'h0000);

    // Threshold flag, immediate threshold disable, then async reset mid-count.
    do_clear();
    threshold = 16'h0010;
    en[3] = 1'b1;
    set_inc(3, 1);
    for (int k = 1; k <= 18; k++) begin
      tick("thr");
      check_eq("thr_hit3", threshold_hit[3], k >= 16);
    end
    threshold = '0;
    #1;
    check_eq("thr_off", threshold_hit, 5'b0);
    repeat (3) tick("thr_more");
    #2 reset_L = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check_eq("async_rst_v", value, '0);
    #1 reset_L = 1'b1;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      clear     = ($urandom_range(0, 49) == 0);
      sat_mode  = $urandom_range(0, 1);
      en        = NCH'($urandom);
      inc       = (NCH*CIS)'($urandom);
      rd_req    = $urandom_range(0, 1);
      rd_clr    = $urandom_range(0, 1);
      rd_ch     = CHW'($urandom_range(0, 7));
      threshold = ($urandom_range(0, 3) == 0) ? '0 : CS'($urandom_range(0, 400));
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
